// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: arbitrates CPU inst/data SRAM-style requests onto a single
// split address/data bus with one transaction outstanding. Data has fixed
// priority over inst. Done pulses are registered (one cycle after bus_data_ok).
// Optional feature macro: SRAM_BRIDGE_KSEG_MAP_EN -- maps kseg0/kseg1 virtual
// addresses (addr[31:30] == 2'b10) to physical by clearing addr[31:29].
module sram_bus_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_done,
  input  logic            data_req,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_done,
  output logic            bus_req,
  output logic            bus_wr,
  output logic [DW/8-1:0] bus_wstrb,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_addr_ok,
  input  logic            bus_data_ok,
  input  logic [DW-1:0]   bus_rdata
);
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   wdata_q;
  logic            done_any;

  // The CPU still holds its request during the done cycle; blocking arbitration
  // then keeps a completed request from being served twice.
  assign done_any = inst_done | data_done;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: data wins ties; address and data phases never overlap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!done_any) begin
          if (data_req)      state_nxt = D_ADDR;
          else if (inst_req) state_nxt = I_ADDR;
        end
      end
      D_ADDR:  if (bus_addr_ok) state_nxt = D_WAIT;
      D_WAIT:  if (bus_data_ok) state_nxt = IDLE;
      I_ADDR:  if (bus_addr_ok) state_nxt = I_WAIT;
      I_WAIT:  if (bus_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning channel's request on leaving IDLE; inst never writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && state_nxt == D_ADDR) begin
      addr_q  <= data_addr;
      wstrb_q <= data_wen;
      wdata_q <= data_wdata;
    end else if (state == IDLE && state_nxt == I_ADDR) begin
      addr_q  <= inst_addr;
      wstrb_q <= '0;
      wdata_q <= '0;
    end
  end

  // Completion: one-cycle done pulse, read data captured only for reads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_done <= (state == I_WAIT) && bus_data_ok;
      data_done <= (state == D_WAIT) && bus_data_ok;
      if (state == I_WAIT && bus_data_ok)
        inst_rdata <= bus_rdata;
      if (state == D_WAIT && bus_data_ok && wstrb_q == '0)
        data_rdata <= bus_rdata;
    end
  end

  assign bus_req   = (state == D_ADDR) || (state == I_ADDR);
  assign bus_wr    = |wstrb_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

`ifdef SRAM_BRIDGE_KSEG_MAP_EN
  // kseg0/kseg1 fold onto the low 512 MB of physical space
  assign bus_addr = (addr_q[AW-1:AW-2] == 2'b10) ? {3'b000, addr_q[AW-4:0]} : addr_q;
`else
  assign bus_addr = addr_q;
`endif

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Bench for sram_bus_bridge: directed latency/priority/reset cases followed by
// randomized concurrent inst/data traffic against a memory responder with
// configurable wait states and a reference memory image.
module tb_sram_bus_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [31:0]   inst_addr;
  logic [31:0]   inst_rdata;
  logic          inst_done;
  logic          data_req;
  logic [3:0]    data_wen;
  logic [31:0]   data_addr;
  logic [31:0]   data_wdata;
  logic [31:0]   data_rdata;
  logic          data_done;
  logic          bus_req;
  logic          bus_wr;
  logic [3:0]    bus_wstrb;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [31:0]   bus_rdata;

  sram_bus_bridge #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory contents ----------------
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] exp_ba(input logic [31:0] a);
`ifdef SRAM_BRIDGE_KSEG_MAP_EN
    if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : hash(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[a] = v;
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = v;
  endfunction

  // ---------------- CPU-side bookkeeping ----------------
  bit          inst_pend = 0;
  bit          data_pend = 0;
  logic [31:0] cur_iaddr = '0;
  logic [31:0] cur_daddr = '0;
  logic [3:0]  cur_wen   = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] exp_drd   = '0;
  int          n_req     = 0;

  // ---------------- memory responder ----------------
  int          addr_dly = 0;
  int          data_dly = 0;
  bit          rnd_mode = 0;
  int          rnd_a    = 0;
  int          rnd_d    = 0;
  int          a_cnt    = 0;
  int          d_cnt    = 0;
  bit          waiting  = 0;
  logic [31:0] rd_val   = '0;
  int          n_bus    = 0;

  assign bus_addr_ok = bus_req && (a_cnt >= (rnd_mode ? rnd_a : addr_dly));
  assign bus_data_ok = waiting && (d_cnt >= (rnd_mode ? rnd_d : data_dly));
  assign bus_rdata   = rd_val;

  // Bus slave: counts wait states, checks each accepted address phase against
  // the CPU request it must belong to, and performs the memory access.
  always @(posedge clk) begin
    if (waiting) begin
      if (bus_data_ok) waiting <= 1'b0;
      else             d_cnt   <= d_cnt + 1;
    end
    if (bus_req && bus_addr_ok) begin
      waiting <= 1'b1;
      d_cnt   <= 0;
      a_cnt   <= 0;
      n_bus   <= n_bus + 1;
      if (data_pend && bus_addr == exp_ba(cur_daddr)) begin
        chk("bus_wr", bus_wr, |cur_wen);
        chk("bus_wstrb", bus_wstrb, cur_wen);
        if (|cur_wen) chk("bus_wdata", bus_wdata, cur_wdata);
      end else if (inst_pend) begin
        chk("bus_iaddr", bus_addr, exp_ba(cur_iaddr));
        chk("bus_iwr", bus_wr, 0);
      end else begin
        chk("bus_spurious", bus_req, 0);
      end
      if (bus_wr) begin
        mem_wr(bus_addr, bus_wstrb, bus_wdata);
        rd_val <= $urandom;
      end else begin
        rd_val <= mem_rd(bus_addr);
      end
      rnd_a <= $urandom_range(0, 3);
      rnd_d <= $urandom_range(0, 4);
    end else if (bus_req) begin
      a_cnt <= a_cnt + 1;
    end else begin
      a_cnt <= 0;
    end
  end

  // ---------------- CPU tasks ----------------
  task automatic cpu_inst(input logic [31:0] a, output int dcyc);
    logic [31:0] exp;
    bit seen;
    seen = 0;
    @(negedge clk);
    inst_addr = a; inst_req = 1'b1; cur_iaddr = a; inst_pend = 1; n_req++;
    exp = ref_rd(exp_ba(a));
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (inst_done) seen = 1;
    end
    dcyc = cyc;
    if (!seen) chk("inst_timeout", inst_done, 1);
    else       chk("inst_rdata", inst_rdata, exp);
    @(negedge clk);
    inst_req = 1'b0; inst_pend = 0;
    chk("inst_done_pulse", inst_done, 0);
  endtask

  task automatic cpu_data(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                          output int dcyc);
    logic [31:0] exp;
    bit seen;
    seen = 0;
    @(negedge clk);
    data_addr = a; data_wen = wen; data_wdata = wd; data_req = 1'b1;
    cur_daddr = a; cur_wen = wen; cur_wdata = wd; data_pend = 1; n_req++;
    if (wen == 4'b0000) exp = ref_rd(exp_ba(a));
    else begin ref_wr(exp_ba(a), wen, wd); exp = exp_drd; end
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (data_done) seen = 1;
    end
    dcyc = cyc;
    if (!seen) chk("data_timeout", data_done, 1);
    else       chk(wen == 4'b0000 ? "data_rdata_load" : "data_rdata_store", data_rdata, exp);
    exp_drd = exp;
    @(negedge clk);
    data_req = 1'b0; data_pend = 0;
    chk("data_done_pulse", data_done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int ci, cd, seen_cnt;
    logic [31:0] ra, rd;
    logic [3:0]  rw;

    resetn = 1'b0; inst_req = 0; inst_addr = '0;
    data_req = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem[32'h0000_0010]     = 32'h2408_0001;
    ref_mem[32'h0000_0010] = 32'h2408_0001;

    // Reset: all outputs low
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_bus_wstrb", bus_wstrb, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_inst", {inst_done, inst_rdata[30:0]}, 0);
    chk("rst_data", {data_done, data_rdata[30:0]}, 0);
    resetn = 1'b1;
    seen_cnt = 0;
    repeat (4) begin @(negedge clk); if (bus_req) seen_cnt++; end
    chk("idle_no_bus_req", seen_cnt, 0);

    // Zero-wait fetch: bus_req cycle 1, done cycle 3
    addr_dly = 0; data_dly = 0;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h0000_0010; cur_iaddr = inst_addr; inst_pend = 1; n_req++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("fetch_bus_req_c%0d", k), bus_req, k == 1);
      chk($sformatf("fetch_done_c%0d", k), inst_done, k == 3);
      if (k == 1) begin
        chk("fetch_bus_addr", bus_addr, 32'h0000_0010);
        chk("fetch_bus_wr", bus_wr, 0);
      end
      if (k == 3) chk("fetch_rdata", inst_rdata, 32'h2408_0001);
    end
    inst_req = 0; inst_pend = 0;

    // Store with partial strobes
    cpu_data(32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, cd);
    cpu_data(32'h0000_0100, 4'b0000, 32'h0, cd);

    // Contention: both requests raised together, data served first
    fork
      cpu_inst(32'h0000_0040, ci);
      cpu_data(32'h0001_0008, 4'b0000, 32'h0, cd);
    join
    chk("contention_data_first", cd < ci, 1);

    // Wait states: addr_ok after 3 extra cycles, data_ok after 5
    addr_dly = 3; data_dly = 5;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h0000_0080; cur_iaddr = inst_addr; inst_pend = 1; n_req++;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("ws_bus_req_c%0d", k), bus_req, k <= 4);
      chk($sformatf("ws_done_c%0d", k), inst_done, k == 11);
      if (k == 11) chk("ws_rdata", inst_rdata, ref_rd(32'h0000_0080));
    end
    inst_req = 0; inst_pend = 0;

    // kseg fetch (mapping only with the feature macro)
    addr_dly = 0; data_dly = 0;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0000; cur_iaddr = inst_addr; inst_pend = 1; n_req++;
    @(negedge clk);
`ifdef SRAM_BRIDGE_KSEG_MAP_EN
    chk("kseg_bus_addr", bus_addr, 32'h1FC0_0000);
`else
    chk("kseg_bus_addr", bus_addr, 32'hBFC0_0000);
`endif
    repeat (2) @(negedge clk);
    chk("kseg_done", inst_done, 1);
    chk("kseg_rdata", inst_rdata, ref_rd(exp_ba(32'hBFC0_0000)));
    @(negedge clk);
    inst_req = 0; inst_pend = 0;

    // Mid-operation reset during D_WAIT; late data_ok must be ignored
    addr_dly = 0; data_dly = 6;
    @(negedge clk);
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h0001_0004;
    cur_daddr = data_addr; cur_wen = 4'b0000; data_pend = 1; n_req++;
    @(negedge clk);
    chk("mrst_addr_phase", bus_req, 1);
    @(negedge clk);
    chk("mrst_in_wait", bus_req, 0);
    @(negedge clk);
    resetn = 0; data_req = 0; data_pend = 0; exp_drd = '0;
    #1;
    chk("mrst_bus_req", bus_req, 0);
    chk("mrst_data_done", data_done, 0);
    @(negedge clk);
    resetn = 1;
    seen_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_done || inst_done || bus_req) seen_cnt++;
    end
    chk("mrst_late_data_ok_ignored", seen_cnt, 0);
    chk("mrst_data_rdata", data_rdata, 0);

    // Randomized concurrent traffic with random wait states
    rnd_mode = 1;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ra = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
          cpu_inst(ra, ci);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ra = 32'h0001_0000 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          rw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
          rd = $urandom;
          cpu_data(ra, rw, rd, cd);
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("bus_txn_count", n_bus, n_req);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
